// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: per-input sync/debounce/edge-detect lanes feeding
// a Moore FSM that produces run enable, clear pulse and lap-freeze controls.

// One conditioning lane: 2-FF synchroniser, tick-qualified debounce, rising-edge event.
module sw_cond #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic evt
);
    logic       meta_q, sync_q;
    logic       stable_q, stable_d;
    logic       stable_dly_q;
    logic [7:0] cnt_q, cnt_d;
    logic       evt_q, evt_d;

    // Debounce: any sample matching the accepted level restarts the count;
    // the new level is accepted on the DEBOUNCE_MS-th consecutive tick.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = 8'd0;
        end else if (tick) begin
            if (cnt_q == 8'(DEBOUNCE_MS - 1)) begin
                stable_d = sync_q;
                cnt_d    = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        // Event fires the cycle after stable rises; falling edge is silent.
        evt_d = stable_q & ~stable_dly_q;
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= 8'd0;
            evt_q        <= 1'b0;
        end else begin
            meta_q       <= raw;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            evt_q        <= evt_d;
        end
    end

    assign evt = evt_q;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       tick_1ms,
    input  logic       sw_start,
    input  logic       sw_clear,
    input  logic       sw_lap,
    output logic       run_en,
    output logic       clear,
    output logic       lap_freeze,
    output logic [1:0] state
);
    localparam int NUM_LANES = 3;
    localparam int L_START = 0;
    localparam int L_CLEAR = 1;
    localparam int L_LAP   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_e;

    logic [NUM_LANES-1:0] raw_vec;
    logic [NUM_LANES-1:0] evt_vec;
    state_e               state_q, state_d;
    logic                 clear_q, clear_d;

    assign raw_vec = {sw_lap, sw_clear, sw_start};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            sw_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_cond (
                .clk  (CLK100MHZ),
                .rst_n(CPU_RESETN),
                .tick (tick_1ms),
                .raw  (raw_vec[g]),
                .evt  (evt_vec[g])
            );
        end
    endgenerate

    // Next state: clear beats start beats lap; losers in the same cycle are dropped.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (evt_vec[L_CLEAR]) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else if (evt_vec[L_START]) begin
            case (state_q)
                IDLE, PAUSE: state_d = RUN;
                default:     state_d = PAUSE;
            endcase
        end else if (evt_vec[L_LAP]) begin
            case (state_q)
                RUN:     state_d = LAP;
                LAP:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // State register; clear is registered so it lines up with the first IDLE cycle.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        run_en     = (state_q == RUN) || (state_q == LAP);
        lap_freeze = (state_q == LAP);
        clear      = clear_q;
        state      = state_q;
    end
endmodule
